// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared states, opcodes and datapath select encodings
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC_R = 4'd2,
        ST_EXEC_I = 4'd3,
        ST_ADDR   = 4'd4,
        ST_MEM_RD = 4'd5,
        ST_MEM_WR = 4'd6,
        ST_WB_ALU = 4'd7,
        ST_WB_MEM = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_FAULT  = 4'd11
    } state_e;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
    localparam logic [1:0] MEM_TO_REG_MDR = 2'b01;
    localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;

    localparam logic [1:0] ALU_B_RT      = 2'b00;
    localparam logic [1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_OR    = 2'b11;

endpackage

// File: rtl/multicycle_controller_stall_timer.sv
// rtl/multicycle_controller_stall_timer.sv - consecutive memory-stall counter with timeout flag
module mc_stall_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic wait_i,
    input  logic ready_i,
    output logic timeout_o
);

    localparam int W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         stalled;

    // The count holds the stall cycles already spent, so the cycle that would
    // make it MEM_TIMEOUT is the one that raises the timeout.
    assign stalled   = wait_i && !ready_i;
    assign timeout_o = stalled && (count_q == LIMIT);

    // Count only uninterrupted stalls; anything else starts over from zero.
    always_comb begin
        count_d = '0;
        if (stalled && !timeout_o) begin
            count_d = count_q + W'(1);
        end
    end

    // Stall count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS-style control FSM with memory stall timeout
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       ir_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       zero_ext_o,
    output logic       lui_o,
    output logic       fault_o,
    output logic [3:0] state_o
);

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic       mem_wait;
    logic       timeout;

    assign mem_wait = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

    mc_stall_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_stall_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wait_i   (mem_wait),
        .ready_i  (mem_ready_i),
        .timeout_o(timeout)
    );

    // The IR is only valid in DECODE, so capture it there and hold it for the rest of the instruction.
    assign opcode_d = (state_q == ST_DECODE) ? opcode_i : opcode_q;

    // State and latched opcode registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (timeout)          state_d = ST_FAULT;
                else if (mem_ready_i) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode_d)
                    OP_R:           state_d = ST_EXEC_R;
                    OP_ORI, OP_LUI: state_d = ST_EXEC_I;
                    OP_LW, OP_SW:   state_d = ST_ADDR;
                    OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                    OP_J, OP_JAL:   state_d = ST_JUMP;
                    default:        state_d = ST_FAULT;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
            ST_ADDR:   state_d = (opcode_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (timeout)          state_d = ST_FAULT;
                else if (mem_ready_i) state_d = ST_WB_MEM;
            end
            ST_MEM_WR: begin
                if (timeout)          state_d = ST_FAULT;
                else if (mem_ready_i) state_d = ST_FETCH;
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_FAULT;
        endcase
    end

    // Control decode; everything is forced quiet while reset is held so no write escapes an abort.
    always_comb begin
        pc_write_o   = 1'b0;
        pc_src_o     = PC_SRC_ALU;
        ir_write_o   = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = REG_DST_RT;
        mem_to_reg_o = MEM_TO_REG_ALU;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = ALU_B_RT;
        alu_op_o     = ALU_OP_ADD;
        zero_ext_o   = 1'b0;
        lui_o        = 1'b0;
        if (rst_ni) begin
            case (state_q)
                ST_FETCH: begin
                    mem_read_o  = 1'b1;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                    alu_src_b_o = ALU_B_FOUR;
                end
                ST_DECODE: alu_src_b_o = ALU_B_IMM_SH2;
                ST_EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_OP_FUNCT;
                end
                ST_EXEC_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = ALU_B_IMM;
                    alu_op_o    = ALU_OP_OR;
                    zero_ext_o  = 1'b1;
                    lui_o       = (opcode_q == OP_LUI);
                end
                ST_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = ALU_B_IMM;
                end
                ST_MEM_RD: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_write_o = 1'b1;
                    iord_o      = 1'b1;
                end
                ST_WB_ALU: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = (opcode_q == OP_R) ? REG_DST_RD : REG_DST_RT;
                end
                ST_WB_MEM: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = MEM_TO_REG_MDR;
                end
                ST_BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_OP_SUB;
                    pc_src_o    = PC_SRC_BRANCH;
                    pc_write_o  = (opcode_q == OP_BEQ) ? zero_i : !zero_i;
                end
                ST_JUMP: begin
                    pc_src_o   = PC_SRC_JUMP;
                    pc_write_o = 1'b1;
                    if (opcode_q == OP_JAL) begin
                        reg_write_o  = 1'b1;
                        reg_dst_o    = REG_DST_RA;
                        mem_to_reg_o = MEM_TO_REG_PC;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fault_o = (state_q == ST_FAULT);
    assign state_o = state_q;

endmodule
